// File: rtl/event_encoder_pkg.sv
// ============================================================================
// event_encoder_pkg : shared constants, state encoding and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package event_encoder_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Same mapping as the 3-to-8 decoder this block inverts.
    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc8.sv
// ============================================================================
// prio_enc8 : combinational priority encoder, highest set bit wins
// Rev 1.0
// ============================================================================
`default_nettype none

module prio_enc8
    import event_encoder_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: later (higher) set bits overwrite lower ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                idx = i[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_encoder.sv
// ============================================================================
// event_encoder : captures event pulses, emits one index per event over
//                 valid/ready, highest index first
// Rev 1.0
// ============================================================================
`default_nettype none

module event_encoder
    import event_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         dropped,
    output logic         busy
);

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_load_mask;
    logic [W-1:0]   w_top_idx;
    logic           w_top_any;
    logic           w_load;
    logic [W-1:0]   w_code_next;
    logic           w_valid_next;

    prio_enc8 u_prio (
        .in  (r_pending),
        .idx (w_top_idx),
        .any (w_top_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_code_next  = code;
        w_valid_next = valid;
        case (r_state)
            IDLE: begin
                if (w_top_any) begin
                    w_load       = 1'b1;
                    w_code_next  = w_top_idx;
                    w_valid_next = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (w_top_any) begin
                        w_load       = 1'b1;
                        w_code_next  = w_top_idx;
                        w_valid_next = 1'b1;
                    end else begin
                        w_valid_next = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_load_mask = w_load ? onehot(w_top_idx) : '0;

    // A req on the bit being loaded re-arms it as a fresh event, so it is
    // excluded from the drop detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            code      <= '0;
            valid     <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= (r_pending & ~w_load_mask) | req;
            code      <= w_code_next;
            valid     <= w_valid_next;
            dropped   <= |(req & r_pending & ~w_load_mask);
        end
    end

    assign busy = valid | (|r_pending);

endmodule

`default_nettype wire

// File: tb/tb_event_encoder.sv
// ============================================================================
// tb_event_encoder : scoreboard bench for event_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_event_encoder;
    import event_encoder_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ready = 1'b0;
    logic [W-1:0] code;
    logic         valid;
    logic         dropped;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    event_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .dropped (dropped),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, int'(n >= 40), 0);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_code: got %0d expected none", code);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (code != e) begin
                    bad++;
                    $display("FAIL scoreboard_code: got %0d expected %0d", code, e);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_code", code, 0);
        check("rst_dropped", dropped, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single event
        ready = 1'b1;
        req = 8'b0000_0100;
        exp_q.push_back(3'd2);
        tick();
        req = '0;
        check("single_latency_valid", valid, 0);
        tick();
        check("single_valid", valid, 1);
        check("single_code", code, 2);
        tick();
        check("single_done", valid, 0);
        wait_idle("single");

        // Burst of all eight lines
        req = 8'hFF;
        for (int i = 7; i >= 0; i--) exp_q.push_back(i[W-1:0]);
        tick();
        req = '0;
        tick();
        for (int i = 7; i >= 0; i--) begin
            check("burst_valid", valid, 1);
            check("burst_code", code, i);
            tick();
        end
        check("burst_end_valid", valid, 0);
        check("burst_end_busy", busy, 0);

        // Backpressure
        ready = 1'b0;
        req = 8'b1001_0000;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
        tick();
        req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", valid, 1);
            check("bp_code", code, 7);
            tick();
        end
        ready = 1'b1;
        tick();
        check("bp_next_valid", valid, 1);
        check("bp_next_code", code, 4);
        tick();
        check("bp_end_valid", valid, 0);
        wait_idle("bp");

        // Drop: bit 1 requested twice while blocked behind bit 7
        ready = 1'b0;
        req = 8'h80;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd1);
        tick();
        req = '0;
        tick();
        check("drop_hold_code", code, 7);
        req = 8'b0000_0010;
        tick();
        check("drop_first", dropped, 0);
        tick();
        req = '0;
        check("drop_pulse", dropped, 1);
        tick();
        check("drop_clear", dropped, 0);
        ready = 1'b1;
        wait_idle("drop");

        // Same-bit re-arm: req[6] coincides with loading bit 6
        req = 8'h40;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd6);
        tick();
        tick();
        req = '0;
        check("rearm_dropped", dropped, 0);
        check("rearm_code1", code, 6);
        tick();
        check("rearm_valid2", valid, 1);
        check("rearm_code2", code, 6);
        check("rearm_dropped2", dropped, 0);
        tick();
        check("rearm_end", valid, 0);
        wait_idle("rearm");

        // Asynchronous reset in the middle of a handshake
        ready = 1'b0;
        req = 8'b0010_0000;
        tick();
        req = '0;
        tick();
        check("arst_pre_code", code, 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_code", code, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("arst_after_busy", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
